// File: rtl/alu_sequencer.sv
// Control sequencer for the 16-bit ALU: fetches 12-bit instructions, issues ALU opcodes and
// executes jumps/Z-branches. Define ALU_SEQ_PERF_EN to build the retired-instruction counter.
module alu_sequencer #(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [11:0]       imem_data,
    output logic [3:0]        alu_op,
    input  logic              z_in,
    output logic              alu_capture,
    output logic              z_flag,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       retired_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_ZWAIT  = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_JZ   = 4'h3;
    localparam logic [3:0] OP_JNZ  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [AWIDTH-1:0] PC_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [2:0]        state_r;
    logic [AWIDTH-1:0] pc_r;
    logic [3:0]        alu_op_r;
    logic              alu_capture_r;
    logic              z_flag_r;
    logic              z_pending_r;
    logic              busy_r;
    logic              halted_r;
    logic              err_r;

    logic [2:0]        next_state_s;
    logic [AWIDTH-1:0] next_pc_s;
    logic [AWIDTH-1:0] pc_inc_s;
    logic [AWIDTH-1:0] target_s;
    logic [3:0]        opcode_s;
    logic [7:0]        arg_s;
    logic              accept_start_s;
    logic              load_op_s;
    logic              set_halt_s;
    logic              set_err_s;
    logic              retire_s;

    // ALU codes above 0x6 have no ALU function behind them.
    function automatic logic alu_code_legal(input logic [3:0] code);
        return (code <= 4'h6);
    endfunction

    assign opcode_s = imem_data[11:8];
    assign arg_s    = imem_data[7:0];
    assign target_s = AWIDTH'(arg_s);
    assign pc_inc_s = pc_r + PC_ONE;

    // Next-state, next-PC and one-cycle event decode.
    always_comb begin
        next_state_s   = state_r;
        next_pc_s      = pc_r;
        accept_start_s = 1'b0;
        load_op_s      = 1'b0;
        set_halt_s     = 1'b0;
        set_err_s      = 1'b0;
        retire_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                if (start) begin
                    accept_start_s = 1'b1;
                    next_pc_s      = '0;
                    next_state_s   = ST_FETCH;
                end else begin
                    next_state_s   = state_r;
                end
            end
            ST_FETCH: begin
                next_state_s = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode_s)
                    OP_NOP: begin
                        next_pc_s    = pc_inc_s;
                        next_state_s = ST_FETCH;
                        retire_s     = 1'b1;
                    end
                    OP_ALU: begin
                        if (alu_code_legal(arg_s[3:0])) begin
                            load_op_s    = 1'b1;
                            next_state_s = ST_EXEC;
                        end else begin
                            set_err_s    = 1'b1;
                            next_state_s = ST_ERROR;
                        end
                    end
                    OP_JMP: begin
                        next_pc_s    = target_s;
                        next_state_s = ST_FETCH;
                        retire_s     = 1'b1;
                    end
                    OP_JZ: begin
                        // z_flag low means the last ALU result was zero.
                        if (!z_flag_r) begin
                            next_pc_s = target_s;
                        end else begin
                            next_pc_s = pc_inc_s;
                        end
                        next_state_s = ST_FETCH;
                        retire_s     = 1'b1;
                    end
                    OP_JNZ: begin
                        if (z_flag_r) begin
                            next_pc_s = target_s;
                        end else begin
                            next_pc_s = pc_inc_s;
                        end
                        next_state_s = ST_FETCH;
                        retire_s     = 1'b1;
                    end
                    OP_HALT: begin
                        set_halt_s   = 1'b1;
                        next_state_s = ST_HALT;
                        retire_s     = 1'b1;
                    end
                    default: begin
                        set_err_s    = 1'b1;
                        next_state_s = ST_ERROR;
                    end
                endcase
            end
            ST_EXEC: begin
                next_state_s = ST_ZWAIT;
            end
            ST_ZWAIT: begin
                next_pc_s    = pc_inc_s;
                next_state_s = ST_FETCH;
                retire_s     = 1'b1;
            end
            default: begin
                // Unreachable encoding: stop safely and flag it.
                set_err_s    = 1'b1;
                next_state_s = ST_ERROR;
            end
        endcase
    end

    // State, PC and all status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= '0;
            alu_op_r      <= 4'b0000;
            alu_capture_r <= 1'b0;
            z_flag_r      <= 1'b0;
            z_pending_r   <= 1'b0;
            busy_r        <= 1'b0;
            halted_r      <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= next_pc_s;
            alu_capture_r <= (next_state_s == ST_ZWAIT);
            if (accept_start_s) begin
                busy_r      <= 1'b1;
                halted_r    <= 1'b0;
                err_r       <= 1'b0;
                z_flag_r    <= 1'b0;
                z_pending_r <= 1'b0;
            end else begin
                if (load_op_s) begin
                    alu_op_r <= arg_s[3:0];
                end
                if (set_halt_s) begin
                    halted_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
                if (set_err_s) begin
                    err_r  <= 1'b1;
                    busy_r <= 1'b0;
                end
                // The ALU registers Z at the end of ZWAIT, so it is sampled in the following FETCH.
                if (state_r == ST_ZWAIT) begin
                    z_pending_r <= 1'b1;
                end else if ((state_r == ST_FETCH) && z_pending_r) begin
                    z_flag_r    <= z_in;
                    z_pending_r <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] retired_cnt_r;

    // Retired-instruction counter, wraps at 0xFFFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt_r <= 16'h0000;
        end else if (accept_start_s) begin
            retired_cnt_r <= 16'h0000;
        end else if (retire_s) begin
            retired_cnt_r <= retired_cnt_r + 16'h0001;
        end
    end

    assign retired_cnt = retired_cnt_r;
`else
    logic perf_unused_s;
    assign perf_unused_s = retire_s;
    assign retired_cnt   = 16'h0000;
`endif

    assign imem_addr   = pc_r;
    assign alu_op      = alu_op_r;
    assign alu_capture = alu_capture_r;
    assign z_flag      = z_flag_r;
    assign busy        = busy_r;
    assign halted      = halted_r;
    assign err         = err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a synchronous-read instruction ROM model.
module tb_alu_sequencer;

`ifdef ALU_SEQ_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  imem_addr;
    logic [11:0] imem_data;
    logic [3:0]  alu_op;
    logic        z_in;
    logic        alu_capture;
    logic        z_flag;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] retired_cnt;

    logic [11:0] rom [0:255];
    int          n_cmp;
    int          n_err;

    alu_sequencer #(.AWIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .alu_op      (alu_op),
        .z_in        (z_in),
        .alu_capture (alu_capture),
        .z_flag      (z_flag),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROM: data valid the cycle after the address.
    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_rom(input logic [11:0] word);
        for (int i = 0; i < 256; i++) rom[i] = word;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_addr"},    32'(imem_addr),   32'h0);
        check_eq({tag, "_aluop"},   32'(alu_op),      32'h0);
        check_eq({tag, "_capture"}, 32'(alu_capture), 32'h0);
        check_eq({tag, "_zflag"},   32'(z_flag),      32'h0);
        check_eq({tag, "_busy"},    32'(busy),        32'h0);
        check_eq({tag, "_halted"},  32'(halted),      32'h0);
        check_eq({tag, "_err"},     32'(err),         32'h0);
        check_eq({tag, "_retired"}, 32'(retired_cnt), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        z_in  = 1'b0;
        fill_rom(12'h000);
        tick(2);
        check_reset_state("rst");
        reset = 1'b0;
        tick(1);

        // ALU op then HALT, Z non-zero.
        rom[0] = 12'h101;
        rom[1] = 12'hF00;
        z_in   = 1'b1;
        pulse_start();
        check_eq("t1_c1_addr", 32'(imem_addr), 32'h0);
        check_eq("t1_c1_busy", 32'(busy), 32'h1);
        tick(1);
        check_eq("t1_c2_aluop", 32'(alu_op), 32'h0);
        tick(1);
        check_eq("t1_c3_aluop", 32'(alu_op), 32'h1);
        check_eq("t1_c3_capture", 32'(alu_capture), 32'h0);
        tick(1);
        check_eq("t1_c4_capture", 32'(alu_capture), 32'h1);
        tick(1);
        check_eq("t1_c5_capture", 32'(alu_capture), 32'h0);
        check_eq("t1_c5_addr", 32'(imem_addr), 32'h1);
        tick(1);
        check_eq("t1_c6_zflag", 32'(z_flag), 32'h1);
        check_eq("t1_c6_halted", 32'(halted), 32'h0);
        tick(1);
        check_eq("t1_halted", 32'(halted), 32'h1);
        check_eq("t1_busy", 32'(busy), 32'h0);
        check_eq("t1_zflag", 32'(z_flag), 32'h1);
        check_eq("t1_aluop_hold", 32'(alu_op), 32'h1);
        check_eq("t1_retired", 32'(retired_cnt), 32'(2 * PERF));

        // ALU then JZ with zero result: branch taken to 5.
        fill_rom(12'h000);
        rom[0] = 12'h102;
        rom[1] = 12'h305;
        rom[2] = 12'hF00;
        rom[5] = 12'hF00;
        z_in   = 1'b0;
        pulse_start();
        check_eq("t2_halted_clr", 32'(halted), 32'h0);
        check_eq("t2_busy", 32'(busy), 32'h1);
        check_eq("t2_addr0", 32'(imem_addr), 32'h0);
        tick(4);
        check_eq("t2_addr1", 32'(imem_addr), 32'h1);
        tick(2);
        check_eq("t2_addr5", 32'(imem_addr), 32'h5);
        tick(2);
        check_eq("t2_halted", 32'(halted), 32'h1);
        check_eq("t2_zflag", 32'(z_flag), 32'h0);
        check_eq("t2_retired", 32'(retired_cnt), 32'(3 * PERF));

        // Same program, non-zero result: branch untaken.
        z_in = 1'b1;
        pulse_start();
        check_eq("t3_addr0", 32'(imem_addr), 32'h0);
        tick(4);
        check_eq("t3_addr1", 32'(imem_addr), 32'h1);
        tick(2);
        check_eq("t3_addr2", 32'(imem_addr), 32'h2);
        check_eq("t3_zflag", 32'(z_flag), 32'h1);
        tick(2);
        check_eq("t3_halted", 32'(halted), 32'h1);
        check_eq("t3_retired", 32'(retired_cnt), 32'(3 * PERF));

        // JMP to an illegal ALU code.
        fill_rom(12'h000);
        rom[0] = 12'h203;
        rom[3] = 12'h107;
        pulse_start();
        tick(2);
        check_eq("t4_jmp_addr", 32'(imem_addr), 32'h3);
        tick(2);
        check_eq("t4_err", 32'(err), 32'h1);
        check_eq("t4_busy", 32'(busy), 32'h0);
        check_eq("t4_aluop_hold", 32'(alu_op), 32'h2);
        check_eq("t4_retired", 32'(retired_cnt), 32'(1 * PERF));

        // Restart from ERROR onto an illegal opcode.
        rom[0] = 12'h500;
        pulse_start();
        check_eq("t5_err_clr", 32'(err), 32'h0);
        check_eq("t5_addr0", 32'(imem_addr), 32'h0);
        check_eq("t5_busy", 32'(busy), 32'h1);
        tick(2);
        check_eq("t5_err", 32'(err), 32'h1);
        check_eq("t5_busy_low", 32'(busy), 32'h0);
        check_eq("t5_retired", 32'(retired_cnt), 32'h0);

        // All-NOP program: PC wraps, mid-run start pulses ignored.
        fill_rom(12'h000);
        pulse_start();
        tick(101);
        pulse_start();
        tick(60);
        pulse_start();
        tick(2 * 255 - 101 - 1 - 60 - 1);
        check_eq("t6_addr_ff", 32'(imem_addr), 32'hFF);
        check_eq("t6_busy_mid", 32'(busy), 32'h1);
        tick(2);
        check_eq("t6_addr_wrap", 32'(imem_addr), 32'h0);
        check_eq("t6_busy_wrap", 32'(busy), 32'h1);
        check_eq("t6_retired", 32'(retired_cnt), 32'(256 * PERF));

        // Reset while in EXEC.
        rom[0] = 12'h103;
        reset  = 1'b1;
        tick(1);
        reset  = 1'b0;
        pulse_start();
        tick(2);
        check_eq("t7_exec_aluop", 32'(alu_op), 32'h3);
        reset = 1'b1;
        tick(1);
        check_reset_state("t7_rst");
        reset = 1'b0;
        tick(1);
        check_eq("t7_no_capture", 32'(alu_capture), 32'h0);
        check_eq("t7_idle_busy", 32'(busy), 32'h0);
        check_eq("t7_idle_addr", 32'(imem_addr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control sequencer driving the 16-bit ALU's `operation` port and consuming its registered `Z` flag. It fetches 12-bit instructions from a synchronous-read instruction memory, issues ALU operation codes with the correct wait for the ALU's registered result and flag, and executes unconditional and Z-conditional jumps. It sits between the instruction ROM and the ALU; operand muxing stays outside this block.

## Interface
- `AWIDTH`, 8, program counter / instruction address width
- `clk`  in  1  rising-edge clock, shared with the ALU
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin execution at address 0
- `imem_addr`  out  AWIDTH  instruction address (= PC)
- `imem_data`  in  12  instruction word, valid one cycle after `imem_addr`
- `alu_op`  out  4  ALU operation code
- `z_in`  in  1  ALU `Z` (0 = last result zero, 1 = non-zero)
- `alu_capture`  out  1  one-cycle strobe: ALU `dout` holds the result of the issued op
- `z_flag`  out  1  latched `z_in` from the most recent ALU instruction
- `busy`  out  1  high from start acceptance until HALT/ERROR
- `halted`  out  1  sticky, HALT executed
- `err`  out  1  sticky, illegal instruction
- `retired_cnt`  out  16  retired-instruction count (see Configuration)

## Operation
- Instruction: `[11:8]` opcode, `[7:0]` arg. Only the low AWIDTH bits of arg are used as target; `arg[3:0]` is the ALU code.
- 0x0 NOP; 0x1 ALU (`arg[3:0]` must be 0x0–0x6, else illegal); 0x2 JMP arg; 0x3 JZ arg (taken if `z_flag`==0); 0x4 JNZ arg (taken if `z_flag`==1); 0xF HALT; all others illegal.
- States: IDLE, FETCH, DECODE, EXEC, ZWAIT, HALT, ERROR.
- IDLE: `start`=1 → PC=0, clear `halted`/`err`/`z_flag`, `busy`=1, → FETCH.
- FETCH: `imem_addr`=PC → DECODE.
- DECODE: NOP → PC+1, FETCH. JMP / taken branch → PC=arg, FETCH. Untaken branch → PC+1, FETCH. ALU → `alu_op`=arg[3:0], EXEC. HALT → `halted`=1, `busy`=0, HALT. Illegal → `err`=1, `busy`=0, ERROR.
- EXEC: holds `alu_op`; ALU registers `dout` at the end of this cycle → ZWAIT.
- ZWAIT: `alu_capture`=1; ALU registers `Z` at the end of this cycle → PC+1, FETCH. The `z_in` sample is latched into `z_flag` on the first FETCH edge.
- HALT/ERROR: outputs frozen; `start` → behaves as from IDLE (restart at 0).
- `alu_op` holds its last issued value outside EXEC/ZWAIT.
- PC increments modulo 2^AWIDTH (255 → 0 at default).
- `start` while `busy` is ignored.

## Timing
- Reset values: state IDLE, PC=0, `imem_addr`=0, `alu_op`=4'b0000, `alu_capture`=0, `z_flag`=0, `busy`=0, `halted`=0, `err`=0, `retired_cnt`=0.
- `reset` has priority in every state and takes effect on the next edge. A mid-instruction reset abandons the instruction and does not count it.
- Cycles per instruction: NOP/JMP/JZ/JNZ = 2; ALU = 4; HALT = 2, measured to `halted` asserted.
- First `imem_addr` is presented the cycle after `start` is sampled.
- Branch decision uses `z_flag` as of DECODE. An ALU op immediately followed by a branch sees that op's Z.
- `alu_capture` is high exactly one cycle per ALU instruction.

## Configuration
- `ALU_SEQ_PERF_EN` defined: `retired_cnt` increments by 1 on every completed NOP, ALU, jump, branch, and HALT. It wraps at 0xFFFF, clears on `reset` and on accepted `start`. Illegal instructions are not counted.
- Not defined: `retired_cnt` is constant 0 and no counter logic is built.

## Test plan
- Reset, then `start`. Program {0x101, 0xF00} with `z_in`=1 → `alu_op`=0x1 in cycle 3, `alu_capture` in cycle 4, `halted`=1 after cycle 6, `z_flag`=1, `retired_cnt`=2 with PERF.
- Program {0x102, 0x305, …, [5]=0xF00} with `z_in`=0 during ZWAIT → JZ taken, `imem_addr` sequence 0, 1, 5, `halted`=1.
- Same program with `z_in`=1 → JZ untaken, `imem_addr`=2 follows 1.
- Instruction 0x107 or 0x500 → `err`=1, `busy`=0, `alu_op` unchanged, `retired_cnt` unchanged; then `start` → restart at PC=0 with `err` cleared.
- Program of 0x000 at every address, AWIDTH=8 → PC wraps 0xFF → 0x00, `busy` stays 1; `start` pulses mid-run are ignored.
- Assert `reset` during EXEC → next cycle IDLE, all outputs at reset values, no `alu_capture` pulse.
